// File: rtl/ha_array_pkg.sv
// ============================================================================
// Module   : ha_array_pkg
// Brief    : Shared constants and types for the ha_array product accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ha_array_pkg;

  localparam int NUM_ROWS  = 4;
  localparam int T_W       = 9;
  localparam int B_W       = 7;
  localparam int ROW_SHIFT = 2;
  localparam int OUT_W     = 16;
  localparam int ACC_W     = OUT_W + 1;
  localparam int ROW_W     = T_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [B_W-1:0] b;
    logic [T_W-1:0] t;
  } ha_row_t;

endpackage

`default_nettype wire

// File: rtl/ha_row_weight.sv
// ============================================================================
// Module   : ha_row_weight
// Brief    : Combines one row's sum/carry vectors and weights it by row index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ha_row_weight
  import ha_array_pkg::*;
(
  input  ha_row_t          row,
  input  logic [1:0]       row_idx,
  output logic [ACC_W-1:0] contribution
);

  logic [ROW_W-1:0] row_val;
  logic [ACC_W-1:0] row_ext;

  // Carry bits sit two positions above the matching sum bits.
  assign row_val      = ROW_W'(row.t) + (ROW_W'(row.b) << 2);
  assign row_ext      = ACC_W'(row_val);
  assign contribution = row_ext << (ROW_SHIFT * int'(row_idx));

endmodule

`default_nettype wire

// File: rtl/ha_array_accumulator.sv
// ============================================================================
// Module   : ha_array_accumulator
// Brief    : Reconstructs the 8x8 product from four ha_array rows, one per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ha_array_accumulator
  import ha_array_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [B_W-1:0]   ha_array_0_b,
  input  logic [B_W-1:0]   ha_array_1_b,
  input  logic [B_W-1:0]   ha_array_2_b,
  input  logic [B_W-1:0]   ha_array_3_b,
  input  logic [T_W-1:0]   ha_array_0_t,
  input  logic [T_W-1:0]   ha_array_1_t,
  input  logic [T_W-1:0]   ha_array_2_t,
  input  logic [T_W-1:0]   ha_array_3_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] product,
  output logic             overflow
);

  localparam logic [1:0] LAST_ROW = 2'(NUM_ROWS - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]       cnt_q, cnt_d;
  ha_row_t          rows_q [NUM_ROWS];
  ha_row_t          rows_d [NUM_ROWS];
  ha_row_t          rows_in [NUM_ROWS];
  logic [ACC_W-1:0] contribution;

  assign rows_in[0] = '{b: ha_array_0_b, t: ha_array_0_t};
  assign rows_in[1] = '{b: ha_array_1_b, t: ha_array_1_t};
  assign rows_in[2] = '{b: ha_array_2_b, t: ha_array_2_t};
  assign rows_in[3] = '{b: ha_array_3_b, t: ha_array_3_t};

  ha_row_weight u_row_weight (
    .row          (rows_q[cnt_q]),
    .row_idx      (cnt_q),
    .contribution (contribution)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q[OUT_W-1:0];
  assign overflow  = acc_q[OUT_W];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rows_d  = rows_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rows_d  = rows_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + contribution;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_ROW) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < NUM_ROWS; k++) rows_q[k] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rows_q  <= rows_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ha_array_accumulator.sv
// ============================================================================
// Module   : tb_ha_array_accumulator
// Brief    : Randomized self-checking bench with an arithmetic product model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ha_array_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, overflow;
  logic [15:0] product;
  logic [6:0] bv [4];
  logic [8:0] tv [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ha_array_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_b (bv[0]),
    .ha_array_1_b (bv[1]),
    .ha_array_2_b (bv[2]),
    .ha_array_3_b (bv[3]),
    .ha_array_0_t (tv[0]),
    .ha_array_1_t (tv[1]),
    .ha_array_2_t (tv[2]),
    .ha_array_3_t (tv[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full-precision weighted sum of the current row vectors.
  function automatic int true_sum();
    int s = 0;
    for (int k = 0; k < 4; k++)
      s += (int'(tv[k]) + 4 * int'(bv[k])) * (4 ** k);
    return s;
  endfunction

  task automatic clear_rows();
    for (int k = 0; k < 4; k++) begin
      tv[k] = '0;
      bv[k] = '0;
    end
  endtask

  task automatic random_rows();
    for (int k = 0; k < 4; k++) begin
      tv[k] = 9'($urandom);
      bv[k] = 7'($urandom);
    end
  endtask

  // Rows whose weighted sum equals x*y exactly, one base-4 digit of x per row.
  task automatic mult_rows(input int x, input int y);
    int v, b;
    for (int k = 0; k < 4; k++) begin
      v = ((x >> (2 * k)) & 3) * y;
      b = (v >> 2) > 127 ? 127 : (v >> 2);
      bv[k] = 7'(b);
      tv[k] = 9'(v - 4 * b);
    end
  endtask

  // One transaction from the current rows; hold = cycles of output backpressure.
  task automatic do_txn(input string tag, input int hold);
    int s, n;
    logic [15:0] exp_p;
    logic        exp_o;
    s     = true_sum();
    exp_p = 16'(s);
    exp_o = (s >= 65536);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    random_rows();
    n = 0;
    while (!out_valid && n < 12) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_prod"}, 32'(product), 32'(exp_p));
    end
    check({tag, "_product"}, 32'(product), 32'(exp_p));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_o));
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int last_accept, cyc;
    logic [16:0] exp_q [$];
    logic [16:0] e;
    clear_rows();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_product", 32'(product), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    clear_rows();                 do_txn("zero", 0);
    clear_rows(); tv[0] = 9'h001; do_txn("t0", 0);
    clear_rows(); tv[3] = 9'h100; do_txn("t3", 1);
    clear_rows(); bv[1] = 7'h01;  do_txn("b1", 0);
    for (int k = 0; k < 4; k++) begin
      tv[k] = 9'h1FF;
      bv[k] = 7'h7F;
    end
    check("max_model", 32'(true_sum()), 32'd86615);
    do_txn("max", 0);
    mult_rows(200, 150);
    check("mult_model", 32'(true_sum()), 32'd30000);
    do_txn("mult", 3);
    for (int i = 0; i < 6; i++) begin
      random_rows();
      do_txn("rand", int'($urandom_range(0, 2)));
    end

    // Abort after two rows have been accumulated.
    random_rows();
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_product", 32'(product), 32'd0);
    clear_rows(); bv[2] = 7'h03;  do_txn("after_abort", 0);

    // Streaming with in_valid and out_ready held high.
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    last_accept = -1;
    cyc         = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream_product", 32'(product), 32'(e[15:0]));
          check("stream_overflow", 32'(overflow), 32'(e[16]));
        end
      end
      random_rows();
      if (in_ready) begin
        exp_q.push_back(17'(true_sum()));
        if (last_accept >= 0) check("stream_interval", 32'(c - last_accept), 32'd6);
        last_accept = c;
        cyc++;
      end
    end
    in_valid = 1'b0;
    check("stream_accepts", 32'(cyc >= 9), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ha_array_accumulator.md
Name: ha_array_accumulator

Overview:
- Multi-cycle consumer of the half-adder-array compression stage of the 8x8 approximate unsigned multiplier.
- Takes the four row pairs (b, t) emitted by that stage and reconstructs the final product, one row per cycle.
- Uses a valid/ready handshake on both input and output.
- Sits between the ha_array generator and downstream error-metric or datapath logic.

Parameters:
NUM_ROWS, 4, number of ha_array rows (one per x bit pair)
T_W, 9, width of each row's t (sum) vector; t[i] has weight 2^i within the row
B_W, 7, width of each row's b (carry) vector; b[i] has weight 2^(i+2) within the row
ROW_SHIFT, 2, left shift between consecutive rows (row k weighted 2^(ROW_SHIFT*k))
OUT_W, 16, product width

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  row vectors valid
in_ready  out  1  block can accept a new set of rows
ha_array_0_b .. ha_array_3_b  in  7 each  carry vectors, rows 0..3
ha_array_0_t .. ha_array_3_t  in  9 each  sum vectors, rows 0..3
out_valid  out  1  product valid
out_ready  in  1  downstream accepts product
product  out  OUT_W  reconstructed product, mod 2^OUT_W
overflow  out  1  true sum >= 2^OUT_W

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Row value: row_k = t_k + (b_k << 2), 10 bits, zero-extended.
- Total: sum over k of row_k << (2k). Accumulator is OUT_W+1 = 17 bits wide.
- product = acc[15:0]; overflow = acc[16].
- Reset (synchronous, rst=1 at an edge), including mid-operation:
  - state=IDLE, acc=0, cnt=0
  - out_valid=0, in_ready=1 (asserted combinationally while in IDLE), product=0, overflow=0
  - any in-flight operation is discarded.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready: capture all 8 vectors into input registers, acc<=0, cnt<=0, go to ACC.
  - ACC: in_ready=0. Each cycle acc <= acc + (row_cnt << 2*cnt), cnt++. When cnt==NUM_ROWS-1, go to DONE.
  - DONE: out_valid=1; product and overflow stable. On out_ready go to IDLE; in_ready=1 in the following cycle.
- Latency:
  - Accept at edge E0; accumulate at E1..E4; out_valid high from just after E4.
  - With out_ready held high, the transfer completes at E5 and the next accept is possible at E6.
  - Minimum initiation interval is 6 cycles.
- Input handshake:
  - in_valid is ignored outside IDLE.
  - Input ports may change freely after capture; the captured copy is used.
- Output backpressure: in DONE with out_ready=0, the state, product and overflow are held indefinitely.
- Simultaneous in_valid and out_ready in DONE: the output transfer completes; the input is NOT accepted in that cycle.
- cnt is 2 bits and wraps only through the DONE/IDLE path; no other wrap-around is legal.
- All arithmetic is unsigned. No saturation: overflow is flagged, product wraps.

Decomposition:
- Package ha_array_pkg holds:
  - constants NUM_ROWS, T_W, B_W, ROW_SHIFT, OUT_W, ACC_W=OUT_W+1
  - state enum {IDLE, ACC, DONE}
  - packed typedef ha_row_t {b[B_W-1:0], t[T_W-1:0]}
- One combinational sub-module, ha_row_weight: ha_row_t plus row index in, shifted ACC_W-bit row contribution out.
- The top level holds the FSM, input registers and accumulator.

Test Plan:
- All rows zero, in_valid pulse -> out_valid after 5 edges, product=0, overflow=0.
- Only ha_array_0_t=9'h001 -> product=1. Only ha_array_3_t=9'h100 -> product=16384. Only ha_array_1_b=7'h01 -> product=16.
- All t=9'h1FF, all b=7'h7F -> true sum 1019*85=86615, so product=21079, overflow=1.
- Exact-multiplier rows for x=200, y=150 -> product=30000. Hold out_ready=0 for 3 cycles -> product/out_valid stable; in_valid pulses during ACC and DONE are ignored.
- Assert rst during ACC (after 2 rows) -> next cycle out_valid=0, in_ready=1; a new input then yields a correct result with no residue from the aborted one.
- Back-to-back inputs with out_ready tied high -> accepts occur exactly 6 cycles apart, each product correct.
